// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the registered ALU.
//   WIDTH          default datapath width
//   alu_op_e       ALUControl operation codes
//   FLAG_N/Z/C/V   bit positions inside ALUFlags ({N,Z,C,V} = bits 3..0)
package alu_pkg;

  localparam int WIDTH = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_BIC = 3'b101,
    ALU_MOV = 3'b110,
    ALU_MVN = 3'b111
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_if.sv
// alu_if: operand/result bundle of the execute-stage ALU.
//   master: drives a, b, bshift, select, ALUControl; observes Result, ALUFlags
//   slave : the ALU itself
// Handshake: none. The ALU accepts a new operation on every rising clk edge
// and presents its result one cycle later; there is no valid or ready.
interface alu_if #(parameter int WIDTH = 5);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       bshift;
  logic             select;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] Result;
  logic [3:0]       ALUFlags;

  modport master (
    output a, b, bshift, select, ALUControl,
    input  Result, ALUFlags
  );

  modport slave (
    input  a, b, bshift, select, ALUControl,
    output Result, ALUFlags
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational operation and NZCV flag logic.
//   a, bp (already shifted operand), op -> result, flags {N,Z,C,V}
// C and V are meaningful only for ADD/SUB; all other ops force them to 0.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] bp,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] bm;
  logic             carry;
  logic             ovf;

  always_comb begin
    sum    = '0;
    bm     = '0;
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        // SUB is a + ~B' + 1, so C = 1 means no borrow.
        bm     = (op == ALU_SUB) ? ~bp : bp;
        sum    = {1'b0, a} + {1'b0, bm} + {{WIDTH{1'b0}}, (op == ALU_SUB)};
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        // Overflow: same-sign addends producing a sum of the other sign.
        ovf    = (a[WIDTH-1] == bm[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & bp;
      ALU_OR:  result = a | bp;
      ALU_XOR: result = a ^ bp;
      ALU_BIC: result = a & ~bp;
      ALU_MOV: result = bp;
      ALU_MVN: result = ~bp;
      default: result = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_shifter.sv
// alu_shifter: combinational generation of the second operand B'.
//   b, bshift, select -> bp
// With ALU_SHIFTER_EN defined, bp = select ? (b << bshift) : b, where bits
// shifted past the MSB are dropped and zeros enter at the LSB.
// Without ALU_SHIFTER_EN, bp = b and select/bshift are ignored.
module alu_shifter #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       bshift,
  input  logic             select,
  output logic [WIDTH-1:0] bp
);

`ifdef ALU_SHIFTER_EN
  logic [WIDTH-1:0] shifted;

  // Result width is that of b, so overflowing bits are truncated.
  assign shifted = b << bshift;
  assign bp      = select ? shifted : b;
`else
  logic unused_shift;

  assign unused_shift = ^{bshift, select};
  assign bp           = b;
`endif

endmodule

// File: rtl/alu_top.sv
// alu_top: registered WIDTH-bit ALU with optionally barrel-shifted B operand.
//   clk   : rising-edge clock
//   reset : asynchronous active-high, clears Result and ALUFlags
//   bus   : alu_if.slave (a, b, bshift, select, ALUControl in;
//           Result, ALUFlags out, one cycle after the inputs are sampled)
// Optional feature: define ALU_SHIFTER_EN to compile in the operand shifter.
module alu_top
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic clk,
  input  logic reset,
  alu_if.slave bus
);

  logic [WIDTH-1:0] bp;
  logic [WIDTH-1:0] result_d;
  logic [3:0]       flags_d;

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .b      (bus.b),
    .bshift (bus.bshift),
    .select (bus.select),
    .bp     (bp)
  );

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (bus.a),
    .bp     (bp),
    .op     (alu_op_e'(bus.ALUControl)),
    .result (result_d),
    .flags  (flags_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.Result   <= '0;
      bus.ALUFlags <= '0;
    end else begin
      bus.Result   <= result_d;
      bus.ALUFlags <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_top.sv
// tb_alu_top: directed and randomized bench for alu_top with an
// integer-arithmetic reference model. Follows ALU_SHIFTER_EN like the RTL.
module tb_alu_top;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_if #(.WIDTH(5)) bus ();

  alu_top #(.WIDTH(5)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int to_signed5(input int u);
    return (u >= 16) ? u - 32 : u;
  endfunction

  function automatic void model(input logic [4:0] a, input logic [4:0] b,
                                input logic [1:0] sh, input logic sel,
                                input logic [2:0] op,
                                output logic [4:0] r, output logic [3:0] f);
    int ia, ib, res, sres;
    logic c, v;
    ia = int'(a);
    ib = int'(b);
`ifdef ALU_SHIFTER_EN
    if (sel) ib = (ib * (1 << int'(sh))) % 32;
`else
    if (sel && sh == 2'd3) ib = int'(b);
`endif
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        res  = (ia + ib) % 32;
        c    = (ia + ib) >= 32;
        sres = to_signed5(ia) + to_signed5(ib);
        v    = (sres > 15) || (sres < -16);
      end
      3'd1: begin
        res  = (ia - ib + 32) % 32;
        c    = (ia >= ib);
        sres = to_signed5(ia) - to_signed5(ib);
        v    = (sres > 15) || (sres < -16);
      end
      3'd2: res = ia & ib;
      3'd3: res = ia | ib;
      3'd4: res = ia ^ ib;
      3'd5: res = ia & (31 - ib);
      3'd6: res = ib;
      default: res = 31 - ib;
    endcase
    r = 5'(res);
    f = {res >= 16, res == 0, c, v};
  endfunction

  // ---------------- scoreboard ----------------
  logic [4:0] exp_q[$];
  logic [3:0] expf_q[$];

  task automatic check(input string tag, input logic [4:0] r_exp, input logic [3:0] f_exp);
    checks++;
    assert (bus.Result === r_exp) else begin
      errors++;
      $error("FAIL %s Result got %b expected %b", tag, bus.Result, r_exp);
    end
    checks++;
    assert (bus.ALUFlags === f_exp) else begin
      errors++;
      $error("FAIL %s ALUFlags got %b expected %b", tag, bus.ALUFlags, f_exp);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 ns after a rising edge; results are read 1 ns after the
  // edge that captured them.
  task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic [1:0] sh,
                       input logic sel, input logic [2:0] op);
    bus.a          = a;
    bus.b          = b;
    bus.bshift     = sh;
    bus.select     = sel;
    bus.ALUControl = op;
  endtask

  task automatic op_check(input string tag, input logic [4:0] a, input logic [4:0] b,
                          input logic [1:0] sh, input logic sel, input logic [2:0] op,
                          input logic [4:0] r_exp, input logic [3:0] f_exp);
    drive(a, b, sh, sel, op);
    @(posedge clk);
    #1;
    check(tag, r_exp, f_exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] ra, rb, r;
    logic [1:0] rsh;
    logic       rsel;
    logic [2:0] rop;
    logic [3:0] f;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(5'd0, 5'd0, 2'd0, 1'b0, 3'd0);
    #1;
    check("reset_initial", 5'd0, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed cases.
`ifdef ALU_SHIFTER_EN
    op_check("add_shift", 5'd3, 5'd5, 2'd1, 1'b1, 3'd0, 5'b01101, 4'b0000);
`else
    op_check("add_shift", 5'd3, 5'd5, 2'd1, 1'b1, 3'd0, 5'b01000, 4'b0000);
`endif
    op_check("sub_borrow", 5'd3, 5'd5, 2'd0, 1'b0, 3'd1, 5'b11110, 4'b1000);
    op_check("add_ovf", 5'd15, 5'd1, 2'd0, 1'b0, 3'd0, 5'b10000, 4'b1001);
    op_check("add_wrap", 5'd31, 5'd1, 2'd0, 1'b0, 3'd0, 5'b00000, 4'b0110);
    op_check("sub_zero", 5'd5, 5'd5, 2'd0, 1'b0, 3'd1, 5'b00000, 4'b0110);
`ifdef ALU_SHIFTER_EN
    op_check("and_shift", 5'b10110, 5'b00011, 2'd2, 1'b1, 3'd2, 5'b00100, 4'b0000);
    op_check("mov_drop", 5'b10110, 5'b11000, 2'd2, 1'b1, 3'd6, 5'b00000, 4'b0100);
`else
    op_check("and_shift", 5'b10110, 5'b00011, 2'd2, 1'b1, 3'd2, 5'b00010, 4'b0000);
    op_check("mov_drop", 5'b10110, 5'b11000, 2'd2, 1'b1, 3'd6, 5'b11000, 4'b1000);
`endif
    op_check("mvn_zero", 5'd0, 5'd31, 2'd0, 1'b0, 3'd7, 5'b00000, 4'b0100);
    op_check("sub_b0", 5'd7, 5'd0, 2'd0, 1'b0, 3'd1, 5'b00111, 4'b0010);
    op_check("sub_ovf", 5'd0, 5'd16, 2'd0, 1'b0, 3'd1, 5'b10000, 4'b1001);

    // Randomized back-to-back operations, one per cycle.
    for (int i = 0; i < 300; i++) begin
      ra   = 5'($urandom_range(0, 31));
      rb   = 5'($urandom_range(0, 31));
      rsh  = 2'($urandom_range(0, 3));
      rsel = 1'($urandom_range(0, 1));
      rop  = 3'($urandom_range(0, 7));
      model(ra, rb, rsh, rsel, rop, r, f);
      exp_q.push_back(r);
      expf_q.push_back(f);
      drive(ra, rb, rsh, rsel, rop);
      @(posedge clk);
      #1;
      check("random", exp_q.pop_front(), expf_q.pop_front());
    end

    // Asynchronous reset mid-cycle: outputs clear without a clock edge and
    // the operation presented at the time is lost.
    op_check("pre_reset", 5'd3, 5'd5, 2'd0, 1'b0, 3'd1, 5'b11110, 4'b1000);
    drive(5'd9, 5'd4, 2'd0, 1'b0, 3'd0);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", 5'd0, 4'b0000);
    @(posedge clk);
    #1;
    check("reset_hold", 5'd0, 4'b0000);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset", 5'd13, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_top.md
# alu_top

Registered 5-bit ALU with a barrel-shifted second operand. Computes arithmetic and logic results over `a` and an optionally left-shifted `b`. Produces `Result` plus NZCV condition flags, both registered. Serves as the datapath execute stage in the teaching-processor designs.

## Interface
- `WIDTH`, default 5: datapath width of `a`, `b`, `Result`.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high; clears all registers.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B, before shifting.
- `bshift` input 2: logical-left shift amount applied to `b` (0–3).
- `select` input 1: 1 selects shifted `b` as B'; 0 selects raw `b`.
- `ALUControl` input 3: operation code.
- `Result` output WIDTH: registered operation result.
- `ALUFlags` output 4: registered flags {N,Z,C,V}, bit 3 down to bit 0.

## Operation
- B' = select ? (b << bshift) truncated to WIDTH : b. Bits shifted out are discarded and zeros fill from the LSB.
- ALUControl encoding:
  - 000 ADD: a + B'
  - 001 SUB: a + ~B' + 1
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 BIC: a & ~B'
  - 110 MOV: B'
  - 111 MVN: ~B'
- N = Result[WIDTH-1]; Z = (Result == 0).
- ADD/SUB:
  - C = carry-out of the WIDTH-bit sum. For SUB, C=1 means no borrow.
  - V = signed overflow: operands of equal sign (after inverting B' for SUB) and a result of differing sign.
- Logic ops and MOV/MVN: C=0, V=0.
- All arithmetic is modulo 2^WIDTH. Operands are two's complement for V.

## Timing
- Inputs are sampled on each rising `clk`. `Result`/`ALUFlags` reflect those inputs one cycle later. Latency is 1 cycle, with a new operation accepted every cycle and no handshake.
- Reset value: `Result` = 0, `ALUFlags` = 4'b0000.
- `reset` asserted mid-operation clears outputs immediately, without waiting for a clock edge. The in-flight operation is lost.
- First valid result appears at the first rising edge after `reset` deasserts.
- Simultaneous input changes within a cycle: only values present at the edge matter.

## Configuration
- `ALU_SHIFTER_EN` defined: the shifter is compiled in and `select`/`bshift` behave as above.
- Not defined: B' = b always, and `select` and `bshift` are ignored. Results equal the select=0 behaviour.

## Structure
- Package `alu_pkg`:
  - `WIDTH` default constant
  - ALUControl enum (ADD, SUB, AND, OR, XOR, BIC, MOV, MVN)
  - flag bit index constants N=3, Z=2, C=1, V=0
- Sub-modules:
  - `alu_shifter`: combinational B' generation.
  - `alu_core`: combinational op and flag logic.
- `alu_top` instantiates both and holds the output registers.

## Test plan
- Reset: assert `reset` between clock edges -> `Result`=0 and `ALUFlags`=0000 immediately.
- a=3, b=5, ALUControl=000, bshift=1, select=1 -> B'=10, `Result`=13 (01101), `ALUFlags`=0000 one cycle later.
- a=3, b=5, SUB, select=0 -> `Result`=5'b11110, `ALUFlags`=1000 (borrow, so C=0).
- a=15, b=1, ADD, select=0 -> `Result`=5'b10000, `ALUFlags`=1001 (signed overflow).
- a=31, b=1, ADD -> `Result`=0, `ALUFlags`=0110; a=5, b=5, SUB -> `Result`=0, `ALUFlags`=0110.
- a=5'b10110, b=5'b00011, AND, bshift=2, select=1 -> B'=01100, `Result`=00100, `ALUFlags`=0000. Also check b=5'b11000, bshift=2, MOV -> `Result`=0, `ALUFlags`=0100 (bits shifted out are dropped).
